// File: rtl/mem_burst_ctrl_pkg.sv
// Shared definitions for the burst memory controllers.
// Bus width, burst length and controller state encoding.
package mcDefs;

  localparam int BUSWIDTH = 16;
  localparam int BURSTLEN = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_LAST,
    RD,
    RD_LAST
  } ctrlState_t;

  function automatic int pageWidth(input int addrWidth);
    return BUSWIDTH - addrWidth;
  endfunction

endpackage

// File: rtl/mem_burst_addrgen.sv
// Burst address generator: latched page offset plus a 2-bit beat.
// Addresses wrap modulo 2^ADDRWIDTH and never leave the page.
module mem_burst_addrgen #(
  parameter int ADDRWIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 advance,
  input  logic [ADDRWIDTH-1:0] loadOffset,
  output logic [ADDRWIDTH-1:0] curAddr,
  output logic [ADDRWIDTH-1:0] nextAddr,
  output logic [1:0]           beat
);

  logic [ADDRWIDTH-1:0] offset;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset <= '0;
      beat   <= '0;
    end else if (load) begin
      offset <= loadOffset;
      beat   <= '0;
    end else if (advance) begin
      beat <= beat + 2'd1;
    end
  end

  assign curAddr  = offset + ADDRWIDTH'(beat);
  assign nextAddr = curAddr + ADDRWIDTH'(1);

endmodule

// File: rtl/mem_burst_ctrl.sv
// Per-page burst controller between the muxed processor bus and
// a shared synchronous memory array; array side floats when idle.
module mem_burst_ctrl
  import mcDefs::*;
#(
  parameter int ADDRWIDTH = 12,
  parameter logic [pageWidth(ADDRWIDTH)-1:0] PAGE = 4'h2,
  parameter int BURSTLEN = mcDefs::BURSTLEN
) (
  input  logic                 clk,
  input  logic                 resetH,
  input  logic                 ALE,
  input  logic                 rdWr_N,
  input  logic [BUSWIDTH-1:0]  busDataIn,
  output logic [BUSWIDTH-1:0]  busDataOut,
  output logic                 busOE,
  output tri   [ADDRWIDTH-1:0] Addr,
  output tri   [BUSWIDTH-1:0]  DataIn,
  output tri                   rdEn,
  output tri                   wrEn,
  input  logic [BUSWIDTH-1:0]  DataOut
);

  ctrlState_t           state;
  logic [ADDRWIDTH-1:0] addrR;
  logic [BUSWIDTH-1:0]  dataR;
  logic                 rdEnR;
  logic                 wrEnR;
  logic                 busOER;

  logic                 hit;
  logic                 load;
  logic                 advance;
  logic [ADDRWIDTH-1:0] curAddr;
  logic [ADDRWIDTH-1:0] nextAddr;
  logic [1:0]           beat;
  logic                 active;
  logic                 wrPhase;

  assign hit = ALE &&
    (busDataIn[BUSWIDTH-1:ADDRWIDTH] == PAGE);
  assign load    = (state == IDLE) && hit;
  assign advance = (state == WR) || (state == RD);

  mem_burst_addrgen #(
    .ADDRWIDTH(ADDRWIDTH)
  ) uAddrGen (
    .clk       (clk),
    .rst       (resetH),
    .load      (load),
    .advance   (advance),
    .loadOffset(busDataIn[ADDRWIDTH-1:0]),
    .curAddr   (curAddr),
    .nextAddr  (nextAddr),
    .beat      (beat)
  );

  // Beat 3 is the last word; the beat counter wraps back to 0 by itself.
  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state  <= IDLE;
      addrR  <= '0;
      dataR  <= '0;
      rdEnR  <= 1'b0;
      wrEnR  <= 1'b0;
      busOER <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          rdEnR  <= 1'b0;
          wrEnR  <= 1'b0;
          busOER <= 1'b0;
          if (hit) begin
            if (rdWr_N) begin
              state <= RD;
              rdEnR <= 1'b1;
              addrR <= busDataIn[ADDRWIDTH-1:0];
            end else begin
              state <= WR;
            end
          end
        end
        WR: begin
          wrEnR <= 1'b1;
          addrR <= curAddr;
          dataR <= busDataIn;
          if (beat == 2'd3) state <= WR_LAST;
        end
        WR_LAST: begin
          wrEnR <= 1'b0;
          state <= IDLE;
        end
        RD: begin
          busOER <= 1'b1;
          if (beat == 2'd3) begin
            rdEnR <= 1'b0;
            state <= RD_LAST;
          end else begin
            addrR <= nextAddr;
          end
        end
        RD_LAST: begin
          busOER <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign active  = (state != IDLE);
  assign wrPhase = (state == WR) || (state == WR_LAST);

  assign Addr   = active  ? addrR : 'z;
  assign DataIn = wrPhase ? dataR : 'z;
  assign rdEn   = active  ? rdEnR : 1'bz;
  assign wrEn   = active  ? wrEnR : 1'bz;

  assign busOE      = busOER;
  assign busDataOut = busOER ? DataOut : '0;

  assert property (@(posedge clk) disable iff (resetH)
    !(rdEnR && wrEnR));

  assert property (@(posedge clk) disable iff (resetH)
    BURSTLEN == 4);

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
- Memory controller sitting directly upstream of the memory array. It drives the array-side Addr/DataIn/rdEn/wrEn nets of the memory-array interface and consumes DataOut.
- Converts the processor's multiplexed address/data bus transactions into per-word array accesses. Each transaction is an address phase followed by a fixed 4-word burst.
- Several instances share one array, so each claims only its own address page. Each instance tristates its array-side outputs when idle.

Parameters:
- ADDRWIDTH, 12, array address width. Also the width of the page offset.
- PAGE, 4'h2, value of bus address bits [BUSWIDTH-1:ADDRWIDTH] this instance responds to. Width is BUSWIDTH-ADDRWIDTH.
- BURSTLEN, 4, words per transaction. Fixed; it is a parameter only for documentation and assertions.

Ports:
- clk  input  1  system clock, all state on rising edge
- resetH  input  1  asynchronous, active-high reset
- ALE  input  1  address latch enable; high marks the address phase
- rdWr_N  input  1  sampled with ALE; 1 = read burst, 0 = write burst
- busDataIn  input  BUSWIDTH  address (at ALE) or write data from the processor
- busDataOut  output  BUSWIDTH  read data to the processor
- busOE  output  1  high while busDataOut is valid and must be driven onto the bus
- Addr  output tri  ADDRWIDTH  array address
- DataIn  output tri  BUSWIDTH  array write data
- rdEn  output tri  1  array read enable
- wrEn  output tri  1  array write enable
- DataOut  input  BUSWIDTH  array read data, valid one cycle after rdEn (synchronous read)

Behaviour:
- BUSWIDTH comes from mcDefs (16).
- States: IDLE, WR, WR_LAST, RD, RD_LAST. A 2-bit beat counter and a registered ADDRWIDTH offset accompany the FSM.
- Reset: state=IDLE, beat=0, busOE=0, busDataOut=0. Addr/DataIn/rdEn/wrEn are all high-Z.
- IDLE: when ALE=1 and busDataIn[BUSWIDTH-1:ADDRWIDTH]==PAGE, latch offset=busDataIn[ADDRWIDTH-1:0] and go to WR (rdWr_N=0) or RD (rdWr_N=1). Call this cycle T0.
- IDLE, page mismatch: stay in IDLE; all array-side outputs remain Z.
- Write burst:
  - T1..T4 (state WR): capture busDataIn word i at the edge.
  - T2..T5: drive wrEn=1, Addr=offset+i, DataIn=word i, rdEn=0 (registered, one cycle after capture).
  - T5 is WR_LAST; the FSM returns to IDLE at T6.
- Read burst:
  - T1..T4 (state RD): drive rdEn=1, Addr=offset+i, wrEn=0, DataIn=Z.
  - T2..T5: busOE=1 and busDataOut=DataOut (combinational pass-through gated by a registered valid).
  - T5 is RD_LAST; return to IDLE at T6.
- Array-side drive: only in T1..T5 of a claimed burst. rdEn/wrEn are driven 0 (not Z) in burst cycles where they are inactive. Outside a burst all four nets are Z.
- Address arithmetic: offset+i is modulo 2^ADDRWIDTH. 12'hFFE + 3 wraps to 12'h001. The page never changes within a burst.
- ALE outside IDLE: ignored. The burst completes unchanged, and the new address is not latched.
- rdEn and wrEn are never both 1 in the same cycle.
- Reset mid-burst: immediate return to the reset state. All array outputs go Z and busOE goes 0 asynchronously. Any remaining words are not written.
- Back-to-back bursts: the earliest next ALE accepted is T6. IDLE is a single cycle.

Decomposition:
- mcDefs holds BUSWIDTH, BURSTLEN, the state enum (IDLE, WR, WR_LAST, RD, RD_LAST) and the page-field width function.
- Sub-module mem_burst_addrgen (offset register, beat counter, wrap increment) is natural and is kept separate for reuse by other controllers.
- The FSM and tristate drivers stay in mem_burst_ctrl.

Test Plan:
- Write burst, PAGE=2: ALE with 16'h2010, data 1111/2222/3333/4444 on T1..T4 -> wrEn=1 on T2..T5 at Addr 010..013 with matching DataIn; Z from T6.
- Read burst: preload 010..013 with A0..A3 and issue ALE 16'h2010 read -> rdEn on T1..T4; busOE=1 with busDataOut=A0..A3 on T2..T5.
- Page mismatch: ALE 16'h3010 -> state stays IDLE; Addr/DataIn/rdEn/wrEn remain Z; busOE=0 throughout.
- Wrap: write burst at 16'h2FFE -> writes land at FFE, FFF, 000, 001.
- Reset at T3 of a write burst -> outputs go Z in the same cycle; only FFE/010 word 0 is written; the next ALE at any later IDLE cycle is accepted.
- Spurious ALE at T2 of a read burst -> ignored; read completes with the original addresses; no overlap of rdEn and wrEn.
